// File: rtl/cv32e41p_instr_realigner.sv
// cv32e41p_instr_realigner: realigns word fetches into RVC/RV32 instructions with PC tracking
module cv32e41p_instr_realigner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        if_valid_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o
);
  typedef enum logic [1:0] {ALIGNED, MISALIGNED, BRANCH_MIS} state_e;
  state_e state_q;
  logic [31:0] pc_q;
  logic [15:0] hold_q;
  logic lo32, hi32, hold32, mis_c, bm_wait, accept;
  assign lo32 = fetch_rdata_i[1:0] == 2'b11;
  assign hi32 = fetch_rdata_i[17:16] == 2'b11;
  assign hold32 = hold_q[1:0] == 2'b11;
  assign mis_c = state_q == MISALIGNED && !hold32;
  assign bm_wait = state_q == BRANCH_MIS && hi32;
  assign pc_o = pc_q;
  assign instr_compressed_o = instr_aligned_o[1:0] != 2'b11;
  always_comb begin
    instr_aligned_o = state_q == ALIGNED ? (lo32 ? fetch_rdata_i : {16'h0, fetch_rdata_i[15:0]}) :
                      state_q == MISALIGNED ? (hold32 ? {fetch_rdata_i[15:0], hold_q} : {16'h0, hold_q}) :
                      {16'h0, fetch_rdata_i[31:16]};
    instr_valid_o = !rst && !branch_i && (mis_c || (fetch_valid_i && !bm_wait));
    accept = if_valid_i && instr_valid_o;
    fetch_ready_o = !rst && !branch_i && fetch_valid_i && (bm_wait || (accept && !mis_c));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIGNED;
      pc_q <= RESET_PC & ~32'h1;
      hold_q <= 16'h0;
    end else if (branch_i) begin
      state_q <= branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
      pc_q <= branch_addr_i & ~32'h1;
      hold_q <= 16'h0;
    end else begin
      if (accept) pc_q <= pc_q + (instr_compressed_o ? 32'd2 : 32'd4);
      case (state_q)
        ALIGNED: if (accept && !lo32) begin
          hold_q <= fetch_rdata_i[31:16];
          state_q <= MISALIGNED;
        end
        MISALIGNED: if (accept) begin
          if (hold32) hold_q <= fetch_rdata_i[31:16];
          else state_q <= ALIGNED;
        end
        BRANCH_MIS: if (fetch_ready_o) begin
          if (hi32) hold_q <= fetch_rdata_i[31:16];
          state_q <= hi32 ? MISALIGNED : ALIGNED;
        end
        default: state_q <= ALIGNED;
      endcase
    end
  end
endmodule

// File: tb/tb_cv32e41p_instr_realigner.sv
// tb_cv32e41p_instr_realigner: halfword-stream model plus directed checks for the realigner
module tb_cv32e41p_instr_realigner;
  logic clk = 0, rst = 1, fetch_valid_i = 0, branch_i = 0, if_valid_i = 0;
  logic [31:0] fetch_rdata_i = 0, branch_addr_i = 0;
  logic fetch_ready_o, instr_valid_o, instr_compressed_o;
  logic [31:0] instr_aligned_o, pc_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cv32e41p_instr_realigner dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_rdata_i(fetch_rdata_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .if_valid_i(if_valid_i), .instr_valid_o(instr_valid_o), .instr_aligned_o(instr_aligned_o),
    .instr_compressed_o(instr_compressed_o), .pc_o(pc_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [15:0] hq[$];
  logic [31:0] mpc;
  bit skip, known;
  always @(negedge clk) begin
    logic [15:0] av[$];
    int need, c;
    bit iv, pop;
    if (rst) begin
      chk("rst_ready", 32'(fetch_ready_o), 0);
      chk("rst_valid", 32'(instr_valid_o), 0);
      hq.delete();
      mpc = 32'h0;
      skip = 0;
      known = 1;
    end else if (known) begin
      chk("m_pc", pc_o, mpc);
      if (fetch_ready_o && !fetch_valid_i) chk("ready_wo_valid", 1, 0);
      if (branch_i) begin
        chk("m_br_valid", 32'(instr_valid_o), 0);
        chk("m_br_ready", 32'(fetch_ready_o), 0);
        hq.delete();
        mpc = {branch_addr_i[31:1], 1'b0};
        skip = branch_addr_i[1];
      end else begin
        av = hq;
        if (fetch_valid_i) begin
          if (!skip) av.push_back(fetch_rdata_i[15:0]);
          av.push_back(fetch_rdata_i[31:16]);
        end
        need = (av.size() > 0 && av[0][1:0] == 2'b11) ? 2 : 1;
        iv = av.size() >= need;
        pop = fetch_valid_i && (iv ? (if_valid_i && need > hq.size()) : 1'b1);
        chk("m_valid", 32'(instr_valid_o), 32'(iv));
        chk("m_ready", 32'(fetch_ready_o), 32'(pop));
        if (iv) begin
          chk("m_instr", instr_aligned_o, need == 2 ? {av[1], av[0]} : {16'h0, av[0]});
          chk("m_comp", 32'(instr_compressed_o), 32'(need == 1));
        end
        c = (iv && if_valid_i) ? need : 0;
        mpc = mpc + 32'(2 * c);
        repeat (c) av.pop_front();
        if (pop) begin
          hq = av;
          skip = 0;
        end else repeat (c) hq.pop_front();
      end
    end
  end
  task automatic drive(input bit fv, input logic [31:0] rd, input bit ifv, input bit br, input logic [31:0] ba);
    fetch_valid_i = fv;
    fetch_rdata_i = rd;
    if_valid_i = ifv;
    branch_i = br;
    branch_addr_i = ba;
    #2;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [31:0] instr, input logic [31:0] pc, input bit rdy);
    chk({name, "_v"}, 32'(instr_valid_o), 1);
    chk({name, "_i"}, instr_aligned_o, instr);
    chk({name, "_pc"}, pc_o, pc);
    chk({name, "_r"}, 32'(fetch_ready_o), 32'(rdy));
  endtask
  task automatic jump(input logic [31:0] a);
    drive(0, 0, 1, 1, a);
    tick();
  endtask
  logic [31:0] words [8] = '{32'h0041_0113, 32'h4505_4501, 32'h0113_4585, 32'h0001_0041,
                             32'h8082_00a1, 32'h0513_0293, 32'h4581_0005, 32'h0193_4601};
  initial begin
    bit p;
    int k;
    repeat (2) tick();
    rst = 0;
    chk("reset_pc", pc_o, 32'h0);
    drive(1, 32'h0041_0113, 1, 0, 0);
    lit("t1", 32'h0041_0113, 0, 1);
    chk("t1_comp", 32'(instr_compressed_o), 0);
    tick();
    chk("t1_pc", pc_o, 4);
    jump(0);
    drive(1, 32'h0001_4501, 1, 0, 0);
    lit("t2a", 32'h0000_4501, 0, 1);
    chk("t2_comp", 32'(instr_compressed_o), 1);
    tick();
    drive(0, 0, 1, 0, 0);
    lit("t2b", 32'h0000_0001, 2, 0);
    tick();
    chk("t2_pc", pc_o, 4);
    jump(0);
    drive(1, 32'h0113_4501, 1, 0, 0);
    lit("t3a", 32'h0000_4501, 0, 1);
    tick();
    drive(1, 32'h4505_0041, 0, 0, 0);
    tick();
    chk("t3_stall_pc", pc_o, 2);
    drive(1, 32'h4505_0041, 1, 0, 0);
    lit("t3b", 32'h0041_0113, 2, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    lit("t3c", 32'h0000_4505, 6, 0);
    tick();
    chk("t3_pc", pc_o, 8);
    drive(1, 32'h4585_1234, 1, 1, 32'h0000_0107);
    chk("t4_br_valid", 32'(instr_valid_o), 0);
    chk("t4_br_ready", 32'(fetch_ready_o), 0);
    tick();
    chk("t4_tgt", pc_o, 32'h106);
    drive(0, 32'h4585_1234, 1, 0, 0);
    chk("t4_nofetch", 32'(instr_valid_o), 0);
    tick();
    drive(1, 32'h4585_1234, 1, 0, 0);
    lit("t4", 32'h0000_4585, 32'h106, 1);
    tick();
    chk("t4_pc", pc_o, 32'h108);
    jump(32'h202);
    drive(1, 32'h0113_abcd, 1, 0, 0);
    chk("t5_nv", 32'(instr_valid_o), 0);
    chk("t5_pop", 32'(fetch_ready_o), 1);
    tick();
    chk("t5_pc0", pc_o, 32'h202);
    drive(1, 32'hdead_0041, 1, 0, 0);
    lit("t5", 32'h0041_0113, 32'h202, 1);
    tick();
    chk("t5_pc", pc_o, 32'h206);
    jump(0);
    drive(1, 32'h0113_4501, 1, 0, 0);
    tick();
    drive(1, 32'h4505_0041, 1, 1, 32'h40);
    chk("t6_nv", 32'(instr_valid_o), 0);
    chk("t6_nr", 32'(fetch_ready_o), 0);
    tick();
    chk("t6_pc", pc_o, 32'h40);
    drive(0, 0, 1, 0, 0);
    chk("t6_cleared", 32'(instr_valid_o), 0);
    tick();
    jump(0);
    drive(1, 32'h0113_4501, 1, 0, 0);
    tick();
    rst = 1;
    drive(0, 0, 1, 0, 0);
    tick();
    rst = 0;
    chk("t6_rst_pc", pc_o, 32'h0);
    chk("t6_rst_nv", 32'(instr_valid_o), 0);
    jump(32'hffff_fffc);
    drive(1, 32'h0001_4501, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    lit("wrap", 32'h0000_0001, 32'hffff_fffe, 0);
    tick();
    chk("wrap_pc", pc_o, 32'h0);
    jump(32'h2);
    k = 0;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, words[k % 8], $urandom_range(0, 2) != 0, 0, 0);
      p = fetch_valid_i && fetch_ready_o;
      tick();
      if (p) k++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
